// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one RV32I ALU between two requesters
// Captures the ALU result into a one-entry response buffer with valid/ready.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic [2:0]      req0_funct3,
  input  logic            req0_funct7,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  input  logic [2:0]      req1_funct3,
  input  logic            req1_funct7,
  input  logic [TAGW-1:0] req1_tag,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7,
  input  logic [XLEN-1:0] alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_id,
  output logic [TAGW-1:0] rsp_tag
);

  logic last;
  logic slot_free;
  logic win0, win1;
  logic acc0, acc1;

  // last==1 means port 1 was granted most recently, so port 0 wins a tie
  always_comb begin
    slot_free  = ~rsp_valid | rsp_ready;
    win0       = req0_valid & (~req1_valid | last);
    win1       = req1_valid & (~req0_valid | ~last);
    req0_ready = win0 & slot_free & ~rst;
    req1_ready = win1 & slot_free & ~rst;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
  end

  always_comb begin
    alu_in1    = req0_in1;
    alu_in2    = req0_in2;
    alu_funct3 = req0_funct3;
    alu_funct7 = req0_funct7;
    if (win1) begin
      alu_in1    = req1_in1;
      alu_in2    = req1_in2;
      alu_funct3 = req1_funct3;
      alu_funct7 = req1_funct7;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      last      <= 1'b1;
    end else if (acc0 || acc1) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_id    <= acc1;
      rsp_tag   <= acc1 ? req1_tag : req0_tag;
      last      <= acc1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with an RV32I ALU model
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_alu_arbiter;
  localparam int XLEN = 32;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req0_funct7;
  logic [XLEN-1:0] req0_in1, req0_in2;
  logic [2:0]      req0_funct3;
  logic [TAGW-1:0] req0_tag;
  logic            req1_valid, req1_ready, req1_funct7;
  logic [XLEN-1:0] req1_in1, req1_in2;
  logic [2:0]      req1_funct3;
  logic [TAGW-1:0] req1_tag;
  logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
  logic [2:0]      alu_funct3;
  logic            alu_funct7;
  logic            rsp_valid, rsp_ready, rsp_id;
  logic [XLEN-1:0] rsp_data;
  logic [TAGW-1:0] rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_tag(req1_tag),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag)
  );

  always_comb begin
    alu_out = '0;
    case (alu_funct3)
      3'b000: alu_out = alu_funct7 ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
      3'b001: alu_out = alu_in1 << alu_in2[4:0];
      3'b010: alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      3'b011: alu_out = {31'd0, alu_in1 < alu_in2};
      3'b100: alu_out = alu_in1 ^ alu_in2;
      3'b101: alu_out = alu_funct7 ? XLEN'($signed(alu_in1) >>> alu_in2[4:0])
                                   : alu_in1 >> alu_in2[4:0];
      3'b110: alu_out = alu_in1 | alu_in2;
      default: alu_out = alu_in1 & alu_in2;
    endcase
  end

  task automatic check(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [2:0] f3, input logic f7, input logic [TAGW-1:0] t);
    req0_in1 = a; req0_in2 = b; req0_funct3 = f3; req0_funct7 = f7; req0_tag = t;
  endtask

  task automatic set1(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [2:0] f3, input logic f7, input logic [TAGW-1:0] t);
    req1_in1 = a; req1_in2 = b; req1_funct3 = f3; req1_funct7 = f7; req1_tag = t;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    set0(32'h7, 32'h8000000A, 3'b000, 1'b0, 4'd3);
    set1(32'h7, 32'h8000000A, 3'b011, 1'b0, 4'd6);
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    step(); step();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_tag", 32'(rsp_tag), 32'd0);

    // single ADD on port 0
    rst = 1'b0; req1_valid = 1'b0;
    #1;
    check("add_ready0", 32'(req0_ready), 32'd1);
    check("add_ready1", 32'(req1_ready), 32'd0);
    check("add_alu_in2", alu_in2, 32'h8000000A);
    step();
    req0_valid = 1'b0;
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_data", rsp_data, 32'h80000011);
    check("add_id", 32'(rsp_id), 32'd0);
    check("add_tag", 32'(rsp_tag), 32'd3);

    // drain with no request; last stays 0 so port 1 wins the next tie
    step();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_data", rsp_data, 32'h80000011);
    check("drain_tag", 32'(rsp_tag), 32'd3);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("drain_last_r1", 32'(req1_ready), 32'd1);
    check("drain_last_r0", 32'(req0_ready), 32'd0);

    // reset again so last=1, then contention SUB vs SLTU
    rst = 1'b1;
    set0(32'h7, 32'h8000000A, 3'b000, 1'b1, 4'd5);
    #1;
    check("rst2_ready1", 32'(req1_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("cont0_ready0", 32'(req0_ready), 32'd1);
    check("cont0_ready1", 32'(req1_ready), 32'd0);
    check("cont0_f7", 32'(alu_funct7), 32'd1);
    step();
    check("cont0_data", rsp_data, 32'h7FFFFFFD);
    check("cont0_id", 32'(rsp_id), 32'd0);
    check("cont0_tag", 32'(rsp_tag), 32'd5);
    check("cont1_ready1", 32'(req1_ready), 32'd1);
    check("cont1_ready0", 32'(req0_ready), 32'd0);
    step();
    check("cont1_data", rsp_data, 32'h00000001);
    check("cont1_id", 32'(rsp_id), 32'd1);
    check("cont1_tag", 32'(rsp_tag), 32'd6);
    check("cont2_ready0", 32'(req0_ready), 32'd1);
    step();
    check("cont2_data", rsp_data, 32'h7FFFFFFD);
    check("cont2_id", 32'(rsp_id), 32'd0);

    // backpressure for 3 cycles
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'h7FFFFFFD);
      check("bp_id", 32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_ready1", 32'(req1_ready), 32'd1);
    check("bp_rel_ready0", 32'(req0_ready), 32'd0);
    step();
    check("bp_rel_valid", 32'(rsp_valid), 32'd1);
    check("bp_rel_data", rsp_data, 32'h00000001);
    check("bp_rel_id", 32'(rsp_id), 32'd1);

    // shifts and SLT on port 1 alone
    req0_valid = 1'b0;
    set1(32'h80000007, 32'h8000000A, 3'b101, 1'b0, 4'd1);
    #1;
    check("srl_ready1", 32'(req1_ready), 32'd1);
    step();
    check("srl_data", rsp_data, 32'h00200000);
    check("srl_tag", 32'(rsp_tag), 32'd1);
    set1(32'h80000007, 32'h8000000A, 3'b101, 1'b1, 4'd2);
    step();
    check("sra_data", rsp_data, 32'hFFE00000);
    check("sra_tag", 32'(rsp_tag), 32'd2);
    set1(32'h7, 32'h8000000A, 3'b010, 1'b0, 4'd4);
    step();
    check("slt_data", rsp_data, 32'h00000000);
    check("slt_id", 32'(rsp_id), 32'd1);
    check("slt_tag", 32'(rsp_tag), 32'd4);

    // reset while a response is pending and both ports are valid
    req0_valid = 1'b1; rsp_ready = 1'b0; rst = 1'b1;
    #1;
    check("mid_rst_ready0", 32'(req0_ready), 32'd0);
    check("mid_rst_ready1", 32'(req1_ready), 32'd0);
    step();
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_data", rsp_data, 32'd0);
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    step();
    check("post_rst_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_data", rsp_data, 32'h7FFFFFFD);
    check("post_rst_id", 32'(rsp_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single RV32I ALU (operands, funct3, funct7, 32-bit result) between two requesters: port 0, the execute stage, and port 1, the address/branch helper. Each request port has a valid/ready handshake. A round-robin arbiter drives the ALU operand and function lines, and the combinational ALU result is captured into a one-entry response buffer with its own valid/ready handshake. The block sits between the decode/execute control and the `alu` instance.

## Interface
- XLEN, 32, operand/result width
- TAGW, 4, width of the opaque request tag returned with the result
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_in1, req0_in2 / req1_in1, req1_in2  in  XLEN  operands
- req0_funct3 / req1_funct3  in  3  ALU function
- req0_funct7 / req1_funct7  in  1  funct7 bit 5 (SUB/SRA select)
- req0_tag / req1_tag  in  TAGW  returned unchanged with the result
- alu_in1, alu_in2  out  XLEN  to the ALU
- alu_funct3  out  3  to the ALU
- alu_funct7  out  1  to the ALU
- alu_out  in  XLEN  combinational ALU result
- rsp_valid  out  1  response buffer full
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  XLEN  registered ALU result
- rsp_id  out  1  requester that issued the result (0/1)
- rsp_tag  out  TAGW  tag of that request

## Operation
- `slot_free = ~rsp_valid | rsp_ready`. No request is accepted unless `slot_free` is true.
- Arbitration is combinational from `req*_valid` and the `last` register:
  - one valid requester: that requester wins;
  - both valid: the requester not equal to `last` wins.
- `reqN_ready = winN & slot_free`. Ready never asserts for a requester whose valid is low.
- ALU drive:
  - `alu_*` carries the winner's fields.
  - With no winner, `alu_*` carries port 0's fields; they are don't-care for verification but must not be X-propagated into state.
- Accept (`valid & ready` on port N): `rsp_data<=alu_out`, `rsp_id<=N`, `rsp_tag<=reqN_tag`, `rsp_valid<=1`, `last<=N`.
- Drain without accept (`rsp_valid & rsp_ready` and no accept): `rsp_valid<=0`; data, id and tag hold.
- Simultaneous drain and accept: `rsp_valid` stays 1 and the new result replaces the old one. There is no bubble, so full throughput is 1 op/cycle.
- Backpressure: while `rsp_valid & ~rsp_ready`, both readies are 0. `rsp_data`, `rsp_id` and `rsp_tag` are stable. `last` is unchanged.
- Requesters must hold their fields stable while valid and not ready. The block does not check this.
- Fairness: under continuous contention with an always-ready consumer, grants alternate 0,1,0,1…, so each requester waits at most 1 accept.
- Function semantics belong to the ALU:
  - funct3 000 ADD/SUB by funct7; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7; 110 OR; 111 AND.
  - Shift amount is `in2[4:0]`.
  - Arithmetic wraps modulo 2^XLEN.
- The arbiter never modifies operands.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `rsp_tag=0`;
  - `last=1`, so port 0 wins the first tie.
  - `req*_ready` are 0 in any cycle where `rst=1`.
- Latency: accepted in cycle N, result visible on `rsp_*` with `rsp_valid=1` from cycle N+1.
- Reset mid-operation: a pending response is discarded and no accept occurs in the reset cycle. Requests still valid after reset deassertion are arbitrated normally.
- Ready paths are combinational in `rsp_ready` and `req*_valid`. No combinational path exists from `rsp_ready` to `rsp_data`.

## Test plan
- Reset, then a single ADD on port 0:
  - stimulus: in1=0x00000007, in2=0x8000000A, funct3=000, funct7=0, tag=3;
  - required: req0_ready=1 in the same cycle; next cycle rsp_valid=1, rsp_data=0x80000011, rsp_id=0, rsp_tag=3.
- Contention, both ports valid every cycle, rsp_ready=1:
  - port 0 issues SUB 7-0x8000000A; port 1 issues SLTU on the same operands;
  - required: grants alternate 0,1,0…; first result 0x7FFFFFFD (id 0), next 0x00000001 (id 1).
- Backpressure, rsp_ready=0 for 3 cycles while both ports are valid:
  - required: readies stay 0 and rsp_data holds its value;
  - when rsp_ready rises, an accept occurs in that same cycle and the response is replaced with no gap cycle.
- Shifts on port 1 with in1=0x80000007, in2=0x8000000A:
  - funct3=101, funct7=0 gives 0x00200000;
  - funct7=1 gives 0xFFE00000;
  - SLT on 7 vs 0x8000000A gives 0.
- Reset asserted while rsp_valid=1 and both ports are valid:
  - required: next cycle rsp_valid=0 with no accept during reset;
  - after release, port 0 wins the first tie.
- Drain with no new request:
  - rsp_valid=1, rsp_ready=1, both valids 0;
  - required: next cycle rsp_valid=0, rsp_data unchanged, last unchanged.
